inst_fetch_unit: RTL and testbench

//  Instruction-fetch stage; consumer of the next-PC value from the branch/next-PC adder.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/inst_fetch_unit.sv | 121 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states
//   NOP_INST      : word presented on inst_o while nothing has been fetched yet
//   INST_BYTES    : PC increment between sequential fetches
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage.
// Holds the fetch PC, reads instruction words over a Wishbone classic master
// port and presents each word through a one-entry valid/ready buffer. A
// redirect pulse replaces the sequential PC and kills any fetch in flight.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   pc_next_i, redirect_i  redirect target and 1-cycle redirect pulse
//   inst_o, inst_pc_o      fetched word and its address
//   inst_valid_o/ready_i   downstream handshake
//   wb_*                   Wishbone classic read-only master
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  PC_ADDR    = 32'h8000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] pc_next_i,
    input  logic                  redirect_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  kill_q, kill_d;
    logic                  valid_q, valid_d;
    logic                  capture;
    logic [ADDR_WIDTH-1:0] target;

    // Word-align the redirect target; misaligned targets are silently rounded down.
    assign target = pc_next_i & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        adr_d   = adr_q;
        kill_d  = kill_q;
        valid_d = valid_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                adr_d   = redirect_i ? target : pc_q;
            end
            FETCH: begin
                if (wb_ack_i) begin
                    if (kill_q || redirect_i) begin
                        // Stale word: drop it and restart from the (already updated) pc_q.
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        capture = 1'b1;
                        valid_d = 1'b1;
                        pc_d    = adr_q + ADDR_WIDTH'(INST_BYTES);
                        state_d = HOLD;
                    end
                end else if (redirect_i) begin
                    // Wishbone classic cannot abort, so let the transfer finish and discard it.
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (valid_q && inst_ready_i) begin
                    valid_d = 1'b0;
                    adr_d   = pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // Latest redirect always owns the next fetch address.
        if (redirect_i) pc_d = target;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pc_q      <= PC_ADDR;
            adr_q     <= PC_ADDR;
            kill_q    <= 1'b0;
            valid_q   <= 1'b0;
            inst_o    <= DATA_WIDTH'(NOP_INST);
            inst_pc_o <= PC_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            adr_q   <= adr_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            if (capture) begin
                inst_o    <= wb_dat_i;
                inst_pc_o <= adr_q;
            end
        end
    end

    assign inst_valid_o = valid_q;
    assign wb_cyc_o     = (state_q == FETCH);
    assign wb_stb_o     = wb_cyc_o;
    assign wb_we_o      = 1'b0;
    assign wb_sel_o     = 4'b1111;
    assign wb_adr_o     = adr_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] PC_ADDR = 32'h8000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic        wb_ack;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_next_i    (pc_next),
        .redirect_i   (redirect),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid),
        .inst_ready_i (inst_ready),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_sel_o     (wb_sel),
        .wb_adr_o     (wb_adr),
        .wb_dat_i     (wb_dat),
        .wb_ack_i     (wb_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents seen by the slave.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == PC_ADDR) return 32'h0050_0093;
        return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // ---------------- Wishbone slave with configurable wait states ----------------
    int   fixed_waits = 0;
    bit   rand_waits  = 0;
    bit   spur_en     = 0;   // random acks outside a cycle must be ignored
    bit   ack_force   = 0;
    int   wcnt        = 0;
    int   cur_wait    = 0;

    always @(negedge clk) begin
        #1;
        if (wb_cyc) begin
            if (wcnt == 0) cur_wait = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
            wb_dat = mem_word(wb_adr);
            if (wcnt >= cur_wait) begin
                wb_ack = 1'b1;
                wcnt   = 0;
            end else begin
                wb_ack = ack_force;
                wcnt++;
            end
        end else begin
            wb_ack = ack_force | (spur_en && ($urandom_range(0, 7) == 0));
            wb_dat = $urandom;
            wcnt   = 0;
        end
    end

    // ---------------- Behavioural model ----------------
    // busy    : a bus transfer is outstanding at m_adr
    // restart : one dead cycle before the next transfer (after reset/redirect/killed word)
    // killed  : the outstanding transfer's data is stale
    bit          m_busy, m_restart, m_killed, m_valid;
    logic [31:0] m_next, m_adr, m_inst, m_ipc;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] tgt;
        if (!rst_n) begin
            m_busy = 0; m_restart = 1; m_killed = 0; m_valid = 0;
            m_next = PC_ADDR; m_adr = PC_ADDR; m_inst = NOP; m_ipc = PC_ADDR;
        end else begin
            tgt = {pc_next[31:2], 2'b00};
            if (m_busy) begin
                if (wb_ack) begin
                    m_busy = 0;
                    if (m_killed || redirect) begin
                        m_killed  = 0;
                        m_restart = 1;
                    end else begin
                        m_valid = 1;
                        m_inst  = wb_dat;
                        m_ipc   = m_adr;
                        m_next  = m_adr + 32'd4;
                    end
                end else if (redirect) m_killed = 1;
            end else if (m_restart) begin
                m_restart = 0;
                m_busy    = 1;
                m_adr     = redirect ? tgt : m_next;
            end else if (redirect) begin
                m_valid   = 0;
                m_restart = 1;
            end else if (inst_ready) begin
                m_valid = 0;
                m_busy  = 1;
                m_adr   = m_next;
            end
            if (redirect) m_next = tgt;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc",   {31'd0, wb_cyc},     {31'd0, m_busy});
        chk("stb",   {31'd0, wb_stb},     {31'd0, m_busy});
        chk("we",    {31'd0, wb_we},      32'd0);
        chk("sel",   {28'd0, wb_sel},     32'hF);
        chk("adr",   wb_adr,              m_adr);
        chk("valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("inst",  inst,                m_inst);
        chk("ipc",   inst_pc,             m_ipc);
    end

    // ---------------- Directed + random stimulus ----------------
    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (!(wb_cyc && wb_ack) && n < 20) begin
            nxt();
            n++;
        end
        chk(nm, {31'd0, wb_cyc && wb_ack}, 32'd1);
    endtask

    initial begin
        rst_n = 0; redirect = 0; pc_next = 0; inst_ready = 1;
        nxt();
        // Reset state
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst",  inst,    NOP);
        chk("rst_ipc",   inst_pc, PC_ADDR);
        chk("rst_cyc",   {31'd0, wb_cyc}, 32'd0);
        chk("rst_adr",   wb_adr,  PC_ADDR);

        // 1: first fetch
        rst_n = 1;
        nxt();
        chk("t1_cyc", {31'd0, wb_cyc}, 32'd1);
        chk("t1_adr", wb_adr, 32'h8000_0000);
        inst_ready = 0;
        nxt();
        chk("t1_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_inst",  inst,    32'h0050_0093);
        chk("t1_ipc",   inst_pc, 32'h8000_0000);

        // 2: backpressure
        repeat (5) begin
            nxt();
            chk("t2_hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("t2_hold_inst",  inst, 32'h0050_0093);
            chk("t2_hold_cyc",   {31'd0, wb_cyc}, 32'd0);
        end
        inst_ready = 1;
        nxt();
        chk("t2_cyc", {31'd0, wb_cyc}, 32'd1);
        chk("t2_adr", wb_adr, 32'h8000_0004);
        fixed_waits = 3;
        nxt();
        chk("t2_ipc", inst_pc, 32'h8000_0004);

        // 3: redirect during wait states
        nxt();
        chk("t3_adr0", wb_adr, 32'h8000_0008);
        redirect = 1; pc_next = 32'h8000_0100;
        nxt();
        redirect = 0;
        repeat (3) begin
            chk("t3_adr_stable", wb_adr, 32'h8000_0008);
            chk("t3_cyc", {31'd0, wb_cyc}, 32'd1);
            nxt();
        end
        chk("t3_idle_cyc",   {31'd0, wb_cyc}, 32'd0);
        chk("t3_dropped",    {31'd0, inst_valid}, 32'd0);
        nxt();
        chk("t3_new_adr", wb_adr, 32'h8000_0100);

        // 4: redirect coincident with ack
        wait_ack("t4_ack_timeout");
        redirect = 1; pc_next = 32'h8000_0102; fixed_waits = 0;
        nxt();
        redirect = 0;
        chk("t4_dropped", {31'd0, inst_valid}, 32'd0);
        chk("t4_idle",    {31'd0, wb_cyc}, 32'd0);
        nxt();
        chk("t4_adr", wb_adr, 32'h8000_0100);
        nxt();
        chk("t4_valid", {31'd0, inst_valid}, 32'd1);
        chk("t4_ipc",   inst_pc, 32'h8000_0100);
        redirect = 1; pc_next = 32'h8000_0200; inst_ready = 1;
        nxt();
        redirect = 0; inst_ready = 0;
        chk("t4_hs_redirect_valid", {31'd0, inst_valid}, 32'd0);
        chk("t4_hs_redirect_cyc",   {31'd0, wb_cyc}, 32'd0);
        nxt();
        chk("t4_adr2", wb_adr, 32'h8000_0200);
        nxt();

        // 5: PC wrap
        redirect = 1; pc_next = 32'hFFFF_FFFC;
        nxt();
        redirect = 0;
        nxt();
        chk("t5_adr", wb_adr, 32'hFFFF_FFFC);
        nxt();
        chk("t5_ipc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1; fixed_waits = 3;
        nxt();
        chk("t5_wrap_adr", wb_adr, 32'h0000_0000);
        chk("t5_wrap_cyc", {31'd0, wb_cyc}, 32'd1);

        // 6: reset during a wait state
        rst_n = 0;
        #1;
        chk("t6_cyc_async", {31'd0, wb_cyc}, 32'd0);
        chk("t6_stb_async", {31'd0, wb_stb}, 32'd0);
        ack_force = 1;
        nxt();
        nxt();
        rst_n = 1;
        nxt();
        ack_force = 0;
        chk("t6_restart_cyc",   {31'd0, wb_cyc}, 32'd1);
        chk("t6_restart_adr",   wb_adr, 32'h8000_0000);
        chk("t6_restart_valid", {31'd0, inst_valid}, 32'd0);

        // Random phase
        rand_waits = 1; spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            nxt();
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0:       pc_next = $urandom;
                1:       pc_next = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: pc_next = PC_ADDR + 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                nxt();
                rst_n = 1;
            end
        end
        redirect = 0;
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
